// File: rtl/m68k_bus_responder.sv
// Purpose : 68000 bus responder; sequences DTACK for ROM (SDRAM req/ack), RAM/IO (fixed waits) and unmapped (timeout) cycles.
// Latency : RAM/IO DTACK W+2 edges after the edge that detects AS; ROM DTACK at the edge sampling rom_ack; unmapped after TIMEOUT edges.
// Backpressure: the CPU stalls on DTACK; the SDRAM side stalls via rom_ack, and an open rom_req is always held until rom_ack.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   m68k_as_n/rw/a        : CPU address strobe, direction, word address A[23:1]
//   rom_cs/ram_cs/io_cs   : decoded selects, priority rom > ram > io
//   rom_req/rom_addr      : SDRAM read request (level) and latched word address
//   rom_ack/rom_data      : SDRAM one-cycle completion pulse and read word
//   rom_dout              : latched ROM word for the CPU data mux
//   m68k_dtack_n          : data acknowledge to the CPU, active low
//   timeout_err           : one-cycle pulse when an unmapped cycle is force-terminated

module m68k_bus_responder #(
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m68k_as_n,
    input  logic        m68k_rw,
    input  logic [22:0] m68k_a,
    input  logic        rom_cs,
    input  logic        ram_cs,
    input  logic        io_cs,
    output logic        rom_req,
    output logic [22:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic [15:0] rom_dout,
    output logic        m68k_dtack_n,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_REQ,
        S_WAIT,
        S_ACK,
        S_DRAIN
    } state_t;

    localparam logic [7:0] L_RAM_WAIT = 8'(RAM_WAIT);
    localparam logic [7:0] L_IO_WAIT  = 8'(IO_WAIT);
    // Compare against TIMEOUT-1 so DTACK lands on the TIMEOUT-th edge with AS low.
    localparam logic [7:0] L_TO_LAST  = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_rom_req;
    logic [22:0] r_rom_addr;
    logic [15:0] r_rom_dout;
    logic        r_dtack_n;
    logic        r_timeout_err;

    logic        w_as;
    logic        w_rom_read;

    assign w_as       = ~m68k_as_n;
    assign w_rom_read = rom_cs & m68k_rw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_rom_req     <= 1'b0;
            r_rom_addr    <= 23'd0;
            r_rom_dout    <= 16'd0;
            r_dtack_n     <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_as) begin
                        r_cnt <= 8'd0;
                    end else if (w_rom_read) begin
                        r_rom_req  <= 1'b1;
                        r_rom_addr <= m68k_a;
                        r_cnt      <= 8'd0;
                        r_state    <= S_ROM_REQ;
                    end else if (rom_cs) begin
                        // ROM write: no SDRAM traffic, acknowledged like an IO access.
                        r_cnt   <= L_IO_WAIT;
                        r_state <= S_WAIT;
                    end else if (ram_cs) begin
                        r_cnt   <= L_RAM_WAIT;
                        r_state <= S_WAIT;
                    end else if (io_cs) begin
                        r_cnt   <= L_IO_WAIT;
                        r_state <= S_WAIT;
                    end else if (r_cnt == L_TO_LAST) begin
                        r_cnt         <= 8'd0;
                        r_dtack_n     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_ROM_REQ: begin
                    if (rom_ack) begin
                        r_rom_dout <= rom_data;
                        r_rom_req  <= 1'b0;
                        if (w_as) begin
                            r_dtack_n <= 1'b0;
                            r_state   <= S_ACK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (!w_as) begin
                        // CPU gave up; keep the request open so the SDRAM read is not orphaned.
                        r_state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (rom_ack) begin
                        r_rom_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                S_WAIT: begin
                    if (!w_as) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == 8'd0) begin
                        r_dtack_n <= 1'b0;
                        r_state   <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                S_ACK: begin
                    // Releasing into IDLE guarantees one idle edge before the next access is seen.
                    if (!w_as) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_dtack_n <= 1'b1;
                    r_rom_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_req      = r_rom_req;
    assign rom_addr     = r_rom_addr;
    assign rom_dout     = r_rom_dout;
    assign m68k_dtack_n = r_dtack_n;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_m68k_bus_responder.sv
module tb_m68k_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        m68k_as_n;
    logic        m68k_rw;
    logic [22:0] m68k_a;
    logic        rom_cs;
    logic        ram_cs;
    logic        io_cs;
    logic        rom_req;
    logic [22:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] rom_dout;
    logic        m68k_dtack_n;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    // Scoreboard entry: expected DTACK latency (edges from the detecting edge) and timeout_err at DTACK.
    typedef struct {
        string tag;
        int    lat;
        logic  terr;
    } exp_t;
    exp_t exp_q[$];

    m68k_bus_responder #(.RAM_WAIT(1), .IO_WAIT(0), .TIMEOUT(255)) dut (
        .clk          (clk),
        .reset        (reset),
        .m68k_as_n    (m68k_as_n),
        .m68k_rw      (m68k_rw),
        .m68k_a       (m68k_a),
        .rom_cs       (rom_cs),
        .ram_cs       (ram_cs),
        .io_cs        (io_cs),
        .rom_req      (rom_req),
        .rom_addr     (rom_addr),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .rom_dout     (rom_dout),
        .m68k_dtack_n (m68k_dtack_n),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int lat, input logic terr);
        exp_t e;
        e.tag  = tag;
        e.lat  = lat;
        e.terr = terr;
        exp_q.push_back(e);
    endtask

    // Runs edges until DTACK is seen (bounded), then pops the scoreboard and compares.
    task automatic wait_dtack_and_check(input logic expect_no_req);
        int   n;
        logic terr_at;
        logic saw_req;
        exp_t e;
        n       = -1;
        terr_at = 1'b0;
        saw_req = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (rom_req) saw_req = 1'b1;
            if (!m68k_dtack_n) begin
                n       = i;
                terr_at = timeout_err;
                break;
            end
        end
        tests++;
        assert (exp_q.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard_empty got=%0d expected=nonzero", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_lat"}, n, e.lat);
            chk({e.tag, "_terr"}, {31'd0, terr_at}, {31'd0, e.terr});
            if (expect_no_req) chk({e.tag, "_no_req"}, {31'd0, saw_req}, 32'd0);
        end
    endtask

    task automatic release_as();
        m68k_as_n = 1'b1;
        rom_cs    = 1'b0;
        ram_cs    = 1'b0;
        io_cs     = 1'b0;
        m68k_rw   = 1'b1;
    endtask

    initial begin
        logic dt_seen;
        reset     = 1'b1;
        m68k_as_n = 1'b1;
        m68k_rw   = 1'b1;
        m68k_a    = 23'd0;
        rom_cs    = 1'b0;
        ram_cs    = 1'b0;
        io_cs     = 1'b0;
        rom_ack   = 1'b0;
        rom_data  = 16'd0;
        tick();
        tick();
        chk("rst_dtack", {31'd0, m68k_dtack_n}, 32'd1);
        chk("rst_req",   {31'd0, rom_req}, 32'd0);
        chk("rst_addr",  {9'd0, rom_addr}, 32'd0);
        chk("rst_dout",  {16'd0, rom_dout}, 32'd0);
        chk("rst_terr",  {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();

        // ROM read with ack 5 cycles after the request appears
        m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_rw = 1'b1; m68k_a = 23'h012345;
        tick();
        chk("rom_req_issue", {31'd0, rom_req}, 32'd1);
        chk("rom_addr", {9'd0, rom_addr}, 32'h012345);
        m68k_a = 23'h7FFFFF;   // mid-cycle address change must not be recaptured
        for (int i = 0; i < 4; i++) tick();
        chk("rom_no_early_dtack", {31'd0, m68k_dtack_n}, 32'd1);
        rom_ack = 1'b1; rom_data = 16'hBEEF;
        tick();
        rom_ack = 1'b0; rom_data = 16'h0000;
        chk("rom_dtack", {31'd0, m68k_dtack_n}, 32'd0);
        chk("rom_dout", {16'd0, rom_dout}, 32'hBEEF);
        chk("rom_req_drop", {31'd0, rom_req}, 32'd0);
        chk("rom_addr_hold", {9'd0, rom_addr}, 32'h012345);
        release_as();
        tick();
        chk("rom_release", {31'd0, m68k_dtack_n}, 32'd1);
        tick();

        // RAM (RAM_WAIT=1) then IO (IO_WAIT=0)
        m68k_as_n = 1'b0; ram_cs = 1'b1;
        push_exp("ram", 3, 1'b0);
        wait_dtack_and_check(1'b1);
        release_as();
        tick();
        chk("ram_release", {31'd0, m68k_dtack_n}, 32'd1);
        tick();
        m68k_as_n = 1'b0; io_cs = 1'b1;
        push_exp("io", 2, 1'b0);
        wait_dtack_and_check(1'b1);
        release_as();
        tick();
        chk("io_release", {31'd0, m68k_dtack_n}, 32'd1);
        tick();

        // Unmapped access forced off by timeout
        m68k_as_n = 1'b0;
        push_exp("tmo", 255, 1'b1);
        wait_dtack_and_check(1'b1);
        tick();
        chk("tmo_pulse_end", {31'd0, timeout_err}, 32'd0);
        chk("tmo_dtack_hold", {31'd0, m68k_dtack_n}, 32'd0);
        release_as();
        tick();
        chk("tmo_release", {31'd0, m68k_dtack_n}, 32'd1);
        tick();

        // ROM abort: AS rises two cycles after the request
        m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_rw = 1'b1; m68k_a = 23'h000777;
        tick();
        chk("abort_req", {31'd0, rom_req}, 32'd1);
        chk("abort_addr", {9'd0, rom_addr}, 32'h000777);
        tick();
        tick();
        release_as();
        dt_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!m68k_dtack_n) dt_seen = 1'b1;
        end
        chk("abort_req_held", {31'd0, rom_req}, 32'd1);
        rom_ack = 1'b1; rom_data = 16'h1234;
        tick();
        rom_ack = 1'b0; rom_data = 16'h0000;
        if (!m68k_dtack_n) dt_seen = 1'b1;
        chk("abort_no_dtack", {31'd0, dt_seen}, 32'd0);
        chk("abort_req_drop", {31'd0, rom_req}, 32'd0);
        chk("abort_dout_kept", {16'd0, rom_dout}, 32'hBEEF);
        m68k_as_n = 1'b0; ram_cs = 1'b1;
        push_exp("ram_after_abort", 3, 1'b0);
        wait_dtack_and_check(1'b1);
        release_as();
        tick();
        tick();

        // Reset in the middle of a ROM request
        m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_rw = 1'b1; m68k_a = 23'h0ABCDE;
        tick();
        tick();
        reset = 1'b1;
        release_as();
        tick();
        reset = 1'b0;
        chk("mrst_req", {31'd0, rom_req}, 32'd0);
        chk("mrst_dtack", {31'd0, m68k_dtack_n}, 32'd1);
        chk("mrst_addr", {9'd0, rom_addr}, 32'd0);
        chk("mrst_dout", {16'd0, rom_dout}, 32'd0);
        tick();
        m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_rw = 1'b1; m68k_a = 23'h000100;
        tick();
        chk("post_rst_req", {31'd0, rom_req}, 32'd1);
        chk("post_rst_addr", {9'd0, rom_addr}, 32'h000100);
        tick();
        rom_ack = 1'b1; rom_data = 16'hCAFE;
        tick();
        rom_ack = 1'b0; rom_data = 16'h0000;
        chk("post_rst_dtack", {31'd0, m68k_dtack_n}, 32'd0);
        chk("post_rst_dout", {16'd0, rom_dout}, 32'hCAFE);
        release_as();
        tick();
        chk("post_rst_release", {31'd0, m68k_dtack_n}, 32'd1);
        tick();

        // Back-to-back IO with a single AS-high cycle between
        m68k_as_n = 1'b0; io_cs = 1'b1;
        push_exp("b2b_first", 2, 1'b0);
        wait_dtack_and_check(1'b1);
        m68k_as_n = 1'b1;
        tick();
        chk("b2b_gap_high", {31'd0, m68k_dtack_n}, 32'd1);
        m68k_as_n = 1'b0;
        push_exp("b2b_second", 2, 1'b0);
        wait_dtack_and_check(1'b1);
        release_as();
        tick();
        chk("b2b_release", {31'd0, m68k_dtack_n}, 32'd1);
        tick();

        // Decoder errors: priority rom > ram > io, ROM write treated as IO
        m68k_as_n = 1'b0; ram_cs = 1'b1; io_cs = 1'b1;
        push_exp("ram_over_io", 3, 1'b0);
        wait_dtack_and_check(1'b1);
        release_as();
        tick();
        tick();
        m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_rw = 1'b0; ram_cs = 1'b1; m68k_a = 23'h055555;
        push_exp("rom_write", 2, 1'b0);
        wait_dtack_and_check(1'b1);
        chk("rom_write_addr_kept", {9'd0, rom_addr}, 32'h000100);
        release_as();
        tick();
        tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
